// File: rtl/io_port_bank_if.sv
// Bundle of the core IO bus (read/write strobes) and the device-side channel
// handshakes between the core, io_port_bank and the board peripherals.
interface io_port_bank_if #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8
);
  localparam int AWI = $clog2(NUIOIN);
  localparam int AWO = $clog2(NUIOOU);

  // Core side
  logic                     req_in;
  logic [AWI-1:0]           addr_in;
  logic [NUBITS-1:0]        io_in;
  logic                     out_en;
  logic [AWO-1:0]           addr_out;
  logic [NUBITS-1:0]        data_out;

  // Device side
  logic [NUIOIN*NUBITS-1:0] in_data;
  logic [NUIOIN-1:0]        in_valid;
  logic [NUIOIN-1:0]        in_ready;
  logic [NUIOOU*NUBITS-1:0] out_data;
  logic [NUIOOU-1:0]        out_valid;
  logic [NUIOOU-1:0]        out_ready;
  logic [1:0]               ovf;

  modport slave (
    input  req_in, addr_in, out_en, addr_out, data_out,
    input  in_data, in_valid, out_ready,
    output io_in, in_ready, out_data, out_valid, ovf
  );

  modport master (
    output req_in, addr_in, out_en, addr_out, data_out,
    output in_data, in_valid, out_ready,
    input  io_in, in_ready, out_data, out_valid, ovf
  );
endinterface

// File: rtl/io_port_bank.sv
// One-entry holding registers between the core IO bus and NUIOIN/NUIOOU device
// channels. Define IO_OVF_EN to build the sticky overrun/underrun flags on ovf.
module io_port_bank #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8
) (
  input logic           clk,
  input logic           rst,
  io_port_bank_if.slave bus
);
  localparam int AWI = $clog2(NUIOIN);
  localparam int AWO = $clog2(NUIOOU);

  logic [NUIOIN-1:0]        rd_hit, in_ready, load;
  logic [NUIOIN-1:0]        ifull_q, ifull_d;
  logic [NUBITS-1:0]        ireg_q [NUIOIN];
  logic [NUBITS-1:0]        ireg_d [NUIOIN];
  logic [NUIOOU-1:0]        wr_hit;
  logic [NUIOOU-1:0]        ovalid_q, ovalid_d;
  logic [NUBITS-1:0]        oreg_q [NUIOOU];
  logic [NUBITS-1:0]        oreg_d [NUIOOU];
  logic [NUBITS-1:0]        io_in;
  logic [NUIOOU*NUBITS-1:0] out_data;

  // Address decode by per-channel compare: out-of-range addresses match no
  // channel, so they read 0 and write nothing without a separate range check.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_hit = '0;
    wr_hit = '0;
    io_in  = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (bus.addr_in == AWI'(k)) begin
        io_in     = ireg_q[k];
        rd_hit[k] = bus.req_in;
      end
    end
    for (int k = 0; k < NUIOOU; k++) begin
      wr_hit[k] = bus.out_en && (bus.addr_out == AWO'(k));
    end
  end

  // A channel being popped can take new data in the same cycle.
  assign in_ready = ~ifull_q | rd_hit;
  assign load     = bus.in_valid & in_ready;

  // NOTE: combinational next-state logic uses blocking assignments; only the
  // clocked block below uses non-blocking ones.
  always_comb begin
    ireg_d   = ireg_q;
    ifull_d  = ifull_q;
    oreg_d   = oreg_q;
    ovalid_d = ovalid_q;
    for (int k = 0; k < NUIOIN; k++) begin
      if (load[k]) begin
        ireg_d[k]  = bus.in_data[k*NUBITS +: NUBITS];
        ifull_d[k] = 1'b1;
      end else if (rd_hit[k]) begin
        ifull_d[k] = 1'b0;
      end
    end
    for (int k = 0; k < NUIOOU; k++) begin
      if (wr_hit[k]) begin
        oreg_d[k]   = bus.data_out;
        ovalid_d[k] = 1'b1;
      end else if (ovalid_q[k] && bus.out_ready[k]) begin
        ovalid_d[k] = 1'b0;
      end
    end
  end

  // NOTE: the holding registers are reset on purpose: a read of a never-loaded
  // channel must return 0, so these arrays cannot be left as uninitialised RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      ireg_q   <= '{default: '0};
      ifull_q  <= '0;
      oreg_q   <= '{default: '0};
      ovalid_q <= '0;
    end else begin
      ireg_q   <= ireg_d;
      ifull_q  <= ifull_d;
      oreg_q   <= oreg_d;
      ovalid_q <= ovalid_d;
    end
  end

`ifdef IO_OVF_EN
  logic [1:0] ovf_q, ovf_d;
  logic       overrun, underrun;

  // Overrun: a write lands on data the device has not yet taken.
  assign overrun  = |(wr_hit & ovalid_q & ~bus.out_ready);
  assign underrun = |(rd_hit & ~ifull_q);
  assign ovf_d    = ovf_q | {underrun, overrun};

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 2'b00;
`endif

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUIOOU; k++) begin
      out_data[k*NUBITS +: NUBITS] = oreg_q[k];
    end
  end

  assign bus.io_in     = io_in;
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data;
  assign bus.out_valid = ovalid_q;
endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: an 8/8 instance for the main traffic and a
// 6/6 instance for out-of-range addressing.
module tb_io_port_bank;
`ifdef IO_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  io_port_bank_if #(.NUBITS(32), .NUIOIN(8), .NUIOOU(8)) b8 ();
  io_port_bank_if #(.NUBITS(32), .NUIOIN(6), .NUIOOU(6)) b6 ();

  io_port_bank #(.NUBITS(32), .NUIOIN(8), .NUIOOU(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  io_port_bank #(.NUBITS(32), .NUIOIN(6), .NUIOOU(6)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (b6.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    b8.req_in    = 1'b0;
    b8.out_en    = 1'b0;
    b8.in_valid  = '0;
    b8.out_ready = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    b8.out_en   = 1'b1;
    b8.addr_out = 3'd2;
    b8.data_out = 32'hCAFE_0002;
    b8.in_data[32 +: 32] = 32'h0000_0077;
    b8.in_valid = 8'h02;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle8();
    b8.addr_in = 3'd1;
    sb.push_back('{"rst_out_valid", 32'h0});
    sb.push_back('{"rst_in_ready", 32'hFF});
    sb.push_back('{"rst_io_in", 32'h0});
    sb.push_back('{"rst_ovf", 32'h0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(b8.out_valid) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_valid, e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b8.in_ready) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.in_ready, e.val); end
    e = sb.pop_front(); n_checks++;
    if (b8.io_in !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.io_in, e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b8.ovf) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.ovf, e.val); end
  endtask

  task automatic test_out_write();
    exp_t e;
    b8.out_en   = 1'b1;
    b8.addr_out = 3'd3;
    b8.data_out = 32'hDEAD_BEEF;
    sb.push_back('{"wr_out_data3", 32'hDEAD_BEEF});
    sb.push_back('{"wr_out_valid", 32'h08});
    tick();
    idle8();
    e = sb.pop_front(); n_checks++;
    if (b8.out_data[3*32 +: 32] !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_data[3*32 +: 32], e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b8.out_valid) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_valid, e.val); end
    b8.out_ready = 8'h08;
    sb.push_back('{"consume_out_valid", 32'h0});
    tick();
    idle8();
    e = sb.pop_front(); n_checks++;
    if (32'(b8.out_valid) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_valid, e.val); end
  endtask

  task automatic test_write_consume();
    exp_t e;
    b8.out_en   = 1'b1;
    b8.addr_out = 3'd0;
    b8.data_out = 32'h11;
    tick();
    b8.data_out  = 32'h22;
    b8.out_ready = 8'h01;
    sb.push_back('{"wc_out_valid", 32'h01});
    sb.push_back('{"wc_out_data0", 32'h22});
    sb.push_back('{"wc_ovf", 32'h0});
    tick();
    idle8();
    e = sb.pop_front(); n_checks++;
    if (32'(b8.out_valid) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_valid, e.val); end
    e = sb.pop_front(); n_checks++;
    if (b8.out_data[31:0] !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_data[31:0], e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b8.ovf) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.ovf, e.val); end
  endtask

  task automatic test_overrun();
    exp_t e;
    b8.out_en   = 1'b1;
    b8.addr_out = 3'd0;
    b8.data_out = 32'h12;
    sb.push_back('{"ovr_out_data0", 32'h12});
    sb.push_back('{"ovr_ovf", {31'd0, OVF_EN}});
    tick();
    idle8();
    e = sb.pop_front(); n_checks++;
    if (b8.out_data[31:0] !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_data[31:0], e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b8.ovf) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.ovf, e.val); end
  endtask

  task automatic test_input();
    exp_t e;
    b8.in_data[5*32 +: 32] = 32'h55;
    b8.in_valid = 8'h20;
    b8.addr_in  = 3'd5;
    sb.push_back('{"in_ready5_empty", 32'h1});
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(b8.in_ready[5]) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.in_ready[5], e.val); end
    sb.push_back('{"in_ready5_full", 32'h0});
    sb.push_back('{"io_in_55", 32'h55});
    tick();
    idle8();
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(b8.in_ready[5]) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.in_ready[5], e.val); end
    e = sb.pop_front(); n_checks++;
    if (b8.io_in !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.io_in, e.val); end
    // Pop with a concurrent reload of the same channel.
    b8.req_in = 1'b1;
    b8.in_data[5*32 +: 32] = 32'h66;
    b8.in_valid = 8'h20;
    sb.push_back('{"in_ready5_pop", 32'h1});
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(b8.in_ready[5]) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.in_ready[5], e.val); end
    sb.push_back('{"io_in_66", 32'h66});
    sb.push_back('{"in_ready5_reload", 32'h0});
    tick();
    idle8();
    #1;
    e = sb.pop_front(); n_checks++;
    if (b8.io_in !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.io_in, e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b8.in_ready[5]) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.in_ready[5], e.val); end
    b8.req_in = 1'b1;
    sb.push_back('{"in_ready5_popped", 32'h1});
    tick();
    idle8();
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(b8.in_ready[5]) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.in_ready[5], e.val); end
  endtask

  task automatic test_underrun();
    exp_t e;
    b8.addr_in = 3'd6;
    b8.req_in  = 1'b1;
    sb.push_back('{"udr_io_in", 32'h0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (b8.io_in !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.io_in, e.val); end
    sb.push_back('{"udr_ovf", {30'd0, OVF_EN, OVF_EN}});
    tick();
    idle8();
    e = sb.pop_front(); n_checks++;
    if (32'(b8.ovf) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.ovf, e.val); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      b8.out_en   = 1'b1;
      b8.addr_out = 3'(k);
      b8.data_out = 32'hA500_0000 | 32'(k);
      sb.push_back('{$sformatf("b2b_out_data%0d", k), 32'hA500_0000 | 32'(k)});
      tick();
    end
    idle8();
    for (int k = 0; k < 8; k++) begin
      e = sb.pop_front(); n_checks++;
      if (b8.out_data[k*32 +: 32] !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_data[k*32 +: 32], e.val); end
    end
    b8.out_ready = 8'hFF;
    sb.push_back('{"b2b_drain_out_valid", 32'h0});
    tick();
    idle8();
    e = sb.pop_front(); n_checks++;
    if (32'(b8.out_valid) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b8.out_valid, e.val); end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    b6.in_data[32 +: 32] = 32'h99;
    b6.in_valid = 6'h02;
    tick();
    b6.in_valid = '0;
    b6.out_en   = 1'b1;
    b6.addr_out = 3'd7;
    b6.data_out = 32'hFFFF_FFFF;
    b6.req_in   = 1'b1;
    b6.addr_in  = 3'd7;
    sb.push_back('{"oor_io_in", 32'h0});
    #1;
    e = sb.pop_front(); n_checks++;
    if (b6.io_in !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b6.io_in, e.val); end
    sb.push_back('{"oor_out_valid", 32'h0});
    sb.push_back('{"oor_out_data_any", 32'h0});
    sb.push_back('{"oor_ovf", 32'h0});
    sb.push_back('{"oor_in_ready", 32'h3D});
    tick();
    b6.out_en = 1'b0;
    b6.req_in = 1'b0;
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(b6.out_valid) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b6.out_valid, e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(|b6.out_data) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, |b6.out_data, e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b6.ovf) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b6.ovf, e.val); end
    e = sb.pop_front(); n_checks++;
    if (32'(b6.in_ready) !== e.val) begin n_errors++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, b6.in_ready, e.val); end
  endtask

  initial begin
    idle8();
    b8.addr_in  = '0;
    b8.addr_out = '0;
    b8.data_out = '0;
    b8.in_data  = '0;
    b6.req_in    = 1'b0;
    b6.out_en    = 1'b0;
    b6.addr_in   = '0;
    b6.addr_out  = '0;
    b6.data_out  = '0;
    b6.in_data   = '0;
    b6.in_valid  = '0;
    b6.out_ready = '0;

    test_reset();
    test_out_write();
    test_write_consume();
    test_overrun();
    test_input();
    test_underrun();
    test_back_to_back();
    test_out_of_range();

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/io_port_bank.md
# io_port_bank

Peripheral-side responder for the processor core's IO bus. It terminates the core's `req_in`/`addr_in`/`io_in` read path and its `out_en`/`addr_out`/`data_out` write path, and presents NUIOIN input channels and NUIOOU output channels to external devices. Each channel is a one-entry holding register with a valid/ready handshake. It sits between the core and the board-level peripherals, one instance per core.

## Interface
Parameters:
- NUBITS, 32, data width; must equal the core's NUBITS
- NUIOIN, 8, number of input channels (≥2)
- NUIOOU, 8, number of output channels (≥2)

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_in  in  1  core read strobe; pops channel `addr_in`
- addr_in  in  $clog2(NUIOIN)  core read channel
- io_in  out  NUBITS  read data to core; combinational from `addr_in`
- out_en  in  1  core write strobe
- addr_out  in  $clog2(NUIOOU)  core write channel
- data_out  in  NUBITS  core write data
- in_data  in  NUIOIN*NUBITS  device data; channel k at `[k*NUBITS +: NUBITS]`
- in_valid  in  NUIOIN  device offers data on channel k
- in_ready  out  NUIOIN  block accepts channel k this cycle
- out_data  out  NUIOOU*NUBITS  output holding registers, packed like `in_data`
- out_valid  out  NUIOOU  output channel k holds unconsumed data
- out_ready  in  NUIOOU  device consumes output channel k
- ovf  out  2  sticky flags: `[0]` output overrun, `[1]` input underrun

## Operation
- Input channel k has register `ireg[k]` and flag `ifull[k]`.
- `in_ready[k] = !ifull[k] | (req_in & addr_in==k)`. The register accepts new data while it is being popped.
- Load: on `in_valid[k] & in_ready[k]`, `ireg[k] <= in_data[k]` and `ifull[k] <= 1`.
- Pop: on `req_in & addr_in==k` with no load that cycle, `ifull[k] <= 0`.
- Pop and load in the same cycle on the same channel: the register takes the new data and `ifull` stays 1.
- `io_in = ireg[addr_in]` at all times, independent of `req_in`.
- Reading an empty channel returns the stale `ireg` value and sets `ovf[1]`.
- Output channel k has register `oreg[k]` (driven on `out_data`) and flag `out_valid[k]`.
- Write: on `out_en & addr_out==k`, `oreg[k] <= data_out` and `out_valid[k] <= 1`.
- Consume: on `out_valid[k] & out_ready[k]` with no write that cycle, `out_valid[k] <= 0`.
- Write while `out_valid[k] & !out_ready[k]`: the data is overwritten, `out_valid` stays 1, and `ovf[0]` is set.
- Write and consume in the same cycle: new data, `out_valid` stays 1, no overrun.
- Addresses ≥ NUIOIN or ≥ NUIOOU (non-power-of-two counts): reads return 0, writes are ignored, and neither sets a flag.
- `ovf` bits clear only on reset.
- There is no further state machine: each channel is an independent two-state (empty/full) machine.

## Timing
- Reset: all `ireg`, `oreg` = 0; `ifull`, `out_valid`, `ovf` = 0.
- Reset outputs: `in_ready` = all ones; `io_in` = 0.
- Reset dominates every concurrent strobe.
- Core read: `io_in` is valid in the same cycle as `req_in`; the pop takes effect at the following edge.
- Core write: `out_data`/`out_valid` update one edge after `out_en` (latency 1).
- Device input: data is visible on `io_in` one edge after handshake acceptance.
- `in_ready` and `io_in` are combinational. All other outputs are registered.

## Configuration
- `IO_OVF_EN` defined: overrun/underrun detection logic is built, and `ovf` behaves as described.
- `IO_OVF_EN` undefined: the detection logic is removed and `ovf` is tied to 2'b00. All other behaviour is identical.

## Test plan
- Reset mid-traffic: assert `rst` during a write to ch2 and a load on ch1 -> next cycle all `out_valid`=0, `in_ready`=all ones, `io_in`=0, `ovf`=0.
- Output write, then consume: `out_en`, `addr_out`=3, `data_out`=0xDEADBEEF, `out_ready`=0 -> ch3 `out_data`=0xDEADBEEF, `out_valid[3]`=1 next cycle; raise `out_ready[3]` one cycle -> `out_valid[3]`=0.
- Output overrun: ch0 valid, `out_ready[0]`=0, write 0x12 -> `out_data` ch0=0x12, `ovf[0]`=1 (0 without `IO_OVF_EN`).
- Simultaneous write and consume on ch0: `out_valid`=1 and `ovf[0]` unchanged.
- Input load and pop: device offers 0x55 on ch5 -> `in_ready[5]`=0 afterwards.
- Pop with reload: `addr_in`=5 shows `io_in`=0x55. Pulse `req_in` while offering 0x66 -> `in_ready[5]`=1 that cycle, then `io_in`=0x66 and `ifull` stays set.
- Input underrun: `req_in` on empty ch6 -> `io_in`=0, `ovf[1]`=1.
- Out-of-range (NUIOIN=NUIOOU=6): `out_en` to address 7 changes nothing; `io_in` at `addr_in`=7 reads 0; `ovf` stays 0.
